pwm_peripheral: RTL and testbench

Downstream consumer of the SPI register file. Takes the five 8-bit control registers (output enables, PWM enables, duty cycle) and drives 16 registered output pins. Each pin is forced low, held static high, or driven by a shared 8-bit PWM waveform. A clock prescaler sets the PWM frequency. Duty changes are shadowed and applied only at a period boundary, so no pin sees a glitch.

---
 rtl/pwm_peripheral.sv | 60 ++++++
 tb/tb_pwm_peripheral.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// 16-pin output stage: each pin forced low, held high, or driven by a shared 8-bit PWM.
// Latency: one clk from enables/counter state to out; duty takes effect at the next period boundary.
// Backpressure: none; free-running, inputs are always accepted.
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [7:0]    pwm_cnt;
    logic [7:0]    duty_shadow;
    logic          tick;
    logic          wrap;
    logic          pwm_level;
    logic [15:0]   en_out;
    logic [15:0]   en_pwm;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    assign tick = (prescaler == PS_MAX);
    assign wrap = tick && (pwm_cnt == 8'hFF);

    // 0xFF means fully on rather than 255/256, so a "100%" request never dips low.
    assign pwm_level = (duty_shadow == 8'hFF) || (pwm_cnt < duty_shadow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler    <= '0;
            pwm_cnt      <= 8'h00;
            duty_shadow  <= 8'h00;
            period_start <= 1'b0;
            out          <= 16'h0000;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            // Shadow reloads only alongside the counter wrap so no period is cut short.
            if (wrap) begin
                duty_shadow <= pwm_duty_cycle;
            end
            period_start <= wrap;
            out          <= en_out & (~en_pwm | {16{pwm_level}});
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: time-based reference model checked every cycle plus directed period measurements.
module tb_pwm_peripheral;

    localparam int D = 2;
    localparam int P = 256 * D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  en_reg_out_7_0 = 8'hFF;
    logic [7:0]  en_reg_out_15_8 = 8'hFF;
    logic [7:0]  en_reg_pwm_7_0 = 8'hFF;
    logic [7:0]  en_reg_pwm_15_8 = 8'hFF;
    logic [7:0]  pwm_duty_cycle = 8'h80;
    logic [15:0] out;
    logic        period_start;

    int n_assert = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    pwm_peripheral #(.CLK_DIV(D)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: elapsed clocks since reset determine position in the period.
    int          clk_n = 0;
    logic [7:0]  shadow = 8'h00;
    logic [15:0] exp_out = 16'h0000;
    logic        exp_ps = 1'b0;

    function automatic logic [15:0] model_out(input int n, input logic [7:0] sh,
                                              input logic [15:0] eo, input logic [15:0] ep);
        int   tick_idx;
        logic lvl;
        logic [15:0] r;
        tick_idx = (n % P) / D;
        lvl = (sh == 8'hFF) ? 1'b1 : (tick_idx < int'(sh));
        r = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            r[i] = eo[i] ? (ep[i] ? lvl : 1'b1) : 1'b0;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_n   <= 0;
            shadow  <= 8'h00;
            exp_out <= 16'h0000;
            exp_ps  <= 1'b0;
        end else begin
            exp_out <= model_out(clk_n, shadow, {en_reg_out_15_8, en_reg_out_7_0},
                                 {en_reg_pwm_15_8, en_reg_pwm_7_0});
            exp_ps  <= ((clk_n % P) == P - 1);
            if ((clk_n % P) == P - 1) shadow <= pwm_duty_cycle;
            clk_n   <= clk_n + 1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("out", {16'h0, out}, {16'h0, exp_out});
            check("period_start", {31'h0, period_start}, {31'h0, exp_ps});
        end
    end

    task automatic wait_ps(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * P && !seen; i++) begin
            @(negedge clk);
            if (period_start) seen = 1'b1;
        end
        check({name, "_ps_seen"}, {31'h0, seen}, 32'h1);
    endtask

    // Called on the negedge where period_start is visible; measures the next full period on out[15].
    task automatic measure(input string name, input int exp_high, input int write_at,
                           input logic [7:0] write_val);
        int high;
        int ps_pos;
        logic first;
        high = 0;
        ps_pos = 0;
        first = 1'b0;
        for (int i = 1; i <= P; i++) begin
            @(negedge clk);
            if (out[15]) high++;
            if (i == 1) first = out[15];
            if (period_start && ps_pos == 0) ps_pos = i;
            if (i == write_at) pwm_duty_cycle = write_val;
        end
        check({name, "_high"}, high, exp_high);
        check({name, "_first"}, {31'h0, first}, {31'h0, (exp_high > 0)});
        check({name, "_ps_pos"}, ps_pos, P);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        mon_en = 1'b1;
        check("reset_out", {16'h0, out}, 32'h0000);
        check("reset_ps", {31'h0, period_start}, 32'h0);

        rst_n = 1'b1;
        @(negedge clk);
        en_reg_pwm_7_0 = 8'h00;
        repeat (10) @(negedge clk);
        check("first_period_out", {16'h0, out}, 32'h00FF);

        wait_ps("p0");
        measure("pwm50", 256, 300, 8'hFF);
        measure("duty_ff", 512, 300, 8'h00);
        measure("duty_00", 0, 100, 8'h40);
        measure("duty_40", 128, 200, 8'hC0);
        measure("duty_c0", 384, 511, 8'h10);
        measure("wrap_cap", 32, -1, 8'h00);

        en_reg_out_15_8 = 8'h00;
        en_reg_out_7_0  = 8'hFF;
        en_reg_pwm_15_8 = 8'h00;
        en_reg_pwm_7_0  = 8'h00;
        @(negedge clk);
        check("static_on", {16'h0, out}, 32'h00FF);
        en_reg_out_7_0 = 8'h00;
        @(negedge clk);
        check("static_off", {16'h0, out}, 32'h0000);

        en_reg_pwm_15_8 = 8'hFF;
        en_reg_pwm_7_0  = 8'hFF;
        pwm_duty_cycle  = 8'h80;
        begin
            logic [15:0] acc;
            acc = 16'h0000;
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                acc = acc | out;
            end
            check("priority_or", {16'h0, acc}, 32'h0000);
        end

        en_reg_out_15_8 = 8'hFF;
        en_reg_out_7_0  = 8'hFF;
        wait_ps("p_rst");
        repeat (5) @(negedge clk);
        #2;
        check("high_before_rst", {16'h0, out}, 32'hFFFF);
        rst_n = 1'b0;
        #1;
        check("async_rst_out", {16'h0, out}, 32'h0000);
        check("async_rst_ps", {31'h0, period_start}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_shadow0", {16'h0, out}, 32'h0000);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
